// File: rtl/green_phase_scheduler.sv
// Round-robin green-phase scheduler for three signal heads, paced by a 2 Hz tick.
// Green length adapts to the waiting-car count and gaps out early when demand disappears.
module green_phase_scheduler #(
    parameter int T_MIN     = 10,
    parameter int T_ADD_MAX = 15,
    parameter int T_Y       = 4,
    parameter int T_AR      = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [2:0] req,
    input  logic [3:0] cnt0,
    input  logic [3:0] cnt1,
    input  logic [3:0] cnt2,
    output logic [2:0] tf0,
    output logic [2:0] tf1,
    output logic [2:0] tf2,
    output logic [1:0] phase,
    output logic [1:0] state,
    output logic [4:0] remaining,
    output logic       handover
);

    typedef enum logic [1:0] {
        ST_ALL_RED = 2'd0,
        ST_GREEN   = 2'd1,
        ST_YELLOW  = 2'd2
    } st_t;

    localparam logic [4:0] L_T_MIN     = 5'(T_MIN);
    localparam logic [4:0] L_T_ADD_MAX = 5'(T_ADD_MAX);
    localparam logic [4:0] L_T_Y       = 5'(T_Y);
    localparam logic [4:0] L_T_AR      = 5'(T_AR);

    st_t        r_state;
    logic [1:0] r_phase;
    logic [4:0] r_rem;
    logic [4:0] r_g;
    logic [4:0] r_glen;
    logic       r_handover;
    logic [2:0] r_tf0;
    logic [2:0] r_tf1;
    logic [2:0] r_tf2;

    st_t        w_state_nxt;
    logic [1:0] w_phase_nxt;
    logic [4:0] w_rem_nxt;
    logic [4:0] w_g_nxt;
    logic [4:0] w_glen_nxt;
    logic       w_handover_nxt;

    logic [1:0] w_cand1;
    logic [1:0] w_cand2;
    logic [1:0] w_sel;
    logic       w_sel_valid;
    logic [3:0] w_sel_cnt;
    logic [4:0] w_sel_add;
    logic [4:0] w_g_inc;
    logic [4:0] w_rem_dec;
    logic       w_other_req;
    logic       w_cur_req;
    logic       w_exit_green;

    function automatic logic [1:0] next_head(input logic [1:0] p);
        logic [1:0] v;
        case (p)
            2'd0:    v = 2'd1;
            2'd1:    v = 2'd2;
            default: v = 2'd0;
        endcase
        return v;
    endfunction

    function automatic logic [2:0] lamp(input logic [1:0] head, input st_t st, input logic [1:0] ph);
        logic [2:0] v;
        v = 3'b100;
        if (head == ph) begin
            case (st)
                ST_GREEN:  v = 3'b001;
                ST_YELLOW: v = 3'b010;
                default:   v = 3'b100;
            endcase
        end else begin
            v = 3'b100;
        end
        return v;
    endfunction

    // Round-robin candidate selection starting after the last granted head.
    always_comb begin
        w_cand1     = next_head(r_phase);
        w_cand2     = next_head(w_cand1);
        w_sel       = r_phase;
        w_sel_valid = 1'b0;
        if (req[w_cand1]) begin
            w_sel       = w_cand1;
            w_sel_valid = 1'b1;
        end else if (req[w_cand2]) begin
            w_sel       = w_cand2;
            w_sel_valid = 1'b1;
        end else if (req[r_phase]) begin
            w_sel       = r_phase;
            w_sel_valid = 1'b1;
        end else begin
            w_sel_valid = 1'b0;
        end
        case (w_sel)
            2'd0:    w_sel_cnt = cnt0;
            2'd1:    w_sel_cnt = cnt1;
            default: w_sel_cnt = cnt2;
        endcase
        if ({1'b0, w_sel_cnt} > L_T_ADD_MAX) begin
            w_sel_add = L_T_ADD_MAX;
        end else begin
            w_sel_add = {1'b0, w_sel_cnt};
        end
    end

    // Saturating counters and the green exit decision (gap-out included).
    always_comb begin
        w_g_inc      = (r_g == 5'd31) ? 5'd31 : (r_g + 5'd1);
        w_rem_dec    = (r_rem == 5'd0) ? 5'd0 : (r_rem - 5'd1);
        w_cur_req    = req[r_phase];
        w_other_req  = |(req & ~(3'b001 << r_phase));
        w_exit_green = w_other_req &&
                       ((w_g_inc >= r_glen) || ((w_g_inc >= L_T_MIN) && !w_cur_req));
    end

    // Next-state logic; everything only advances on tick cycles.
    always_comb begin
        w_state_nxt    = r_state;
        w_phase_nxt    = r_phase;
        w_rem_nxt      = r_rem;
        w_g_nxt        = r_g;
        w_glen_nxt     = r_glen;
        w_handover_nxt = 1'b0;
        if (tick) begin
            case (r_state)
                ST_ALL_RED: begin
                    if (r_rem != 5'd0) begin
                        w_rem_nxt = w_rem_dec;
                    end else if (w_sel_valid) begin
                        w_state_nxt    = ST_GREEN;
                        w_phase_nxt    = w_sel;
                        w_g_nxt        = 5'd0;
                        w_glen_nxt     = L_T_MIN + w_sel_add;
                        w_rem_nxt      = L_T_MIN + w_sel_add;
                        w_handover_nxt = 1'b1;
                    end else begin
                        w_rem_nxt = 5'd0;
                    end
                end
                ST_GREEN: begin
                    if (w_exit_green) begin
                        w_state_nxt = ST_YELLOW;
                        w_rem_nxt   = L_T_Y;
                        w_g_nxt     = w_g_inc;
                    end else begin
                        w_rem_nxt = w_rem_dec;
                        w_g_nxt   = w_g_inc;
                    end
                end
                ST_YELLOW: begin
                    if (r_rem <= 5'd1) begin
                        w_state_nxt = ST_ALL_RED;
                        w_rem_nxt   = L_T_AR;
                    end else begin
                        w_rem_nxt = w_rem_dec;
                    end
                end
                default: begin
                    w_state_nxt = ST_ALL_RED;
                    w_rem_nxt   = L_T_AR;
                end
            endcase
        end else begin
            w_handover_nxt = 1'b0;
        end
    end

    // State and registered outputs; lamps are decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_ALL_RED;
            r_phase    <= 2'd2;
            r_rem      <= L_T_AR;
            r_g        <= 5'd0;
            r_glen     <= L_T_MIN;
            r_handover <= 1'b0;
            r_tf0      <= 3'b100;
            r_tf1      <= 3'b100;
            r_tf2      <= 3'b100;
        end else begin
            r_state    <= w_state_nxt;
            r_phase    <= w_phase_nxt;
            r_rem      <= w_rem_nxt;
            r_g        <= w_g_nxt;
            r_glen     <= w_glen_nxt;
            r_handover <= w_handover_nxt;
            r_tf0      <= lamp(2'd0, w_state_nxt, w_phase_nxt);
            r_tf1      <= lamp(2'd1, w_state_nxt, w_phase_nxt);
            r_tf2      <= lamp(2'd2, w_state_nxt, w_phase_nxt);
        end
    end

    assign tf0       = r_tf0;
    assign tf1       = r_tf1;
    assign tf2       = r_tf2;
    assign phase     = r_phase;
    assign state     = r_state;
    assign remaining = r_rem;
    assign handover  = r_handover;

endmodule

// File: tb/tb_green_phase_scheduler.sv
// Self-checking bench for green_phase_scheduler: table of tick runs with expected
// outputs, queued as a scoreboard, plus hand-written reset and tick-timing sequences.
module tb_green_phase_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [2:0] req = 3'b000;
    logic [3:0] cnt0 = 4'd0;
    logic [3:0] cnt1 = 4'd0;
    logic [3:0] cnt2 = 4'd0;
    logic [2:0] tf0, tf1, tf2;
    logic [1:0] phase, state;
    logic [4:0] remaining;
    logic       handover;

    int checks = 0;
    int errors = 0;

    green_phase_scheduler dut (
        .clk(clk), .rst(rst), .tick(tick), .req(req),
        .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2),
        .tf0(tf0), .tf1(tf1), .tf2(tf2),
        .phase(phase), .state(state), .remaining(remaining), .handover(handover)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         n;
        logic [2:0] req;
        logic [3:0] c0;
        logic [3:0] c1;
        logic [3:0] c2;
        logic [8:0] tf;
        logic [1:0] st;
        logic [1:0] ph;
        logic [4:0] rem;
        logic       ho;
    } vec_t;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    vec_t vecs[22];
    vec_t exp_q[$];

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        vec_t e;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            cmp({tag, " tf"}, int'({tf0, tf1, tf2}), int'(e.tf));
            cmp({tag, " state"}, int'(state), int'(e.st));
            cmp({tag, " phase"}, int'(phase), int'(e.ph));
            cmp({tag, " remaining"}, int'(remaining), int'(e.rem));
            cmp({tag, " handover"}, int'(handover), int'(e.ho));
        end
    endtask

    task automatic push_exp(input logic [8:0] tfv, input logic [1:0] st, input logic [1:0] ph,
                            input logic [4:0] rem, input logic ho);
        vec_t e;
        e = '{0, 3'b000, 4'd0, 4'd0, 4'd0, tfv, st, ph, rem, ho};
        exp_q.push_back(e);
    endtask

    task automatic do_ticks(input int n);
        repeat (n) begin
            @(negedge clk) tick = 1'b1;
            @(negedge clk) tick = 1'b0;
        end
    endtask

    initial begin
        // n, req, c0, c1, c2, {tf0,tf1,tf2}, state, phase, remaining, handover
        vecs[0]  = '{0,  3'b000, 4'd0,  4'd0, 4'd0, {R, R, R}, 2'd0, 2'd2, 5'd2,  1'b0};
        vecs[1]  = '{2,  3'b001, 4'd3,  4'd0, 4'd0, {R, R, R}, 2'd0, 2'd2, 5'd0,  1'b0};
        vecs[2]  = '{1,  3'b001, 4'd3,  4'd0, 4'd0, {G, R, R}, 2'd1, 2'd0, 5'd13, 1'b1};
        vecs[3]  = '{13, 3'b001, 4'd3,  4'd0, 4'd0, {G, R, R}, 2'd1, 2'd0, 5'd0,  1'b0};
        vecs[4]  = '{5,  3'b001, 4'd3,  4'd0, 4'd0, {G, R, R}, 2'd1, 2'd0, 5'd0,  1'b0};
        vecs[5]  = '{1,  3'b011, 4'd3,  4'd0, 4'd0, {Y, R, R}, 2'd2, 2'd0, 5'd4,  1'b0};
        vecs[6]  = '{3,  3'b011, 4'd3,  4'd0, 4'd0, {Y, R, R}, 2'd2, 2'd0, 5'd1,  1'b0};
        vecs[7]  = '{1,  3'b011, 4'd3,  4'd0, 4'd0, {R, R, R}, 2'd0, 2'd0, 5'd2,  1'b0};
        vecs[8]  = '{2,  3'b011, 4'd3,  4'd0, 4'd0, {R, R, R}, 2'd0, 2'd0, 5'd0,  1'b0};
        vecs[9]  = '{1,  3'b011, 4'd3,  4'd0, 4'd0, {R, G, R}, 2'd1, 2'd1, 5'd10, 1'b1};
        vecs[10] = '{9,  3'b111, 4'd0,  4'd0, 4'd0, {R, G, R}, 2'd1, 2'd1, 5'd1,  1'b0};
        vecs[11] = '{1,  3'b111, 4'd0,  4'd0, 4'd0, {R, Y, R}, 2'd2, 2'd1, 5'd4,  1'b0};
        vecs[12] = '{4,  3'b111, 4'd0,  4'd0, 4'd0, {R, R, R}, 2'd0, 2'd1, 5'd2,  1'b0};
        vecs[13] = '{3,  3'b111, 4'd0,  4'd0, 4'd0, {R, R, G}, 2'd1, 2'd2, 5'd10, 1'b1};
        vecs[14] = '{10, 3'b111, 4'd0,  4'd0, 4'd0, {R, R, Y}, 2'd2, 2'd2, 5'd4,  1'b0};
        vecs[15] = '{7,  3'b111, 4'd0,  4'd0, 4'd0, {G, R, R}, 2'd1, 2'd0, 5'd10, 1'b1};
        vecs[16] = '{10, 3'b111, 4'd0,  4'd0, 4'd0, {Y, R, R}, 2'd2, 2'd0, 5'd4,  1'b0};
        vecs[17] = '{7,  3'b111, 4'd0,  4'd0, 4'd0, {R, G, R}, 2'd1, 2'd1, 5'd10, 1'b1};
        vecs[18] = '{10, 3'b111, 4'd0,  4'd0, 4'd0, {R, Y, R}, 2'd2, 2'd1, 5'd4,  1'b0};
        vecs[19] = '{7,  3'b001, 4'd15, 4'd0, 4'd0, {G, R, R}, 2'd1, 2'd0, 5'd25, 1'b1};
        vecs[20] = '{9,  3'b100, 4'd15, 4'd0, 4'd0, {G, R, R}, 2'd1, 2'd0, 5'd16, 1'b0};
        vecs[21] = '{1,  3'b100, 4'd15, 4'd0, 4'd0, {Y, R, R}, 2'd2, 2'd0, 5'd4,  1'b0};

        repeat (3) @(negedge clk);
        push_exp({R, R, R}, 2'd0, 2'd2, 5'd2, 1'b0);
        check_outputs("reset held");
        rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            req  = vecs[i].req;
            cnt0 = vecs[i].c0;
            cnt1 = vecs[i].c1;
            cnt2 = vecs[i].c2;
            exp_q.push_back(vecs[i]);
            if (vecs[i].n == 0) begin
                repeat (5) @(negedge clk);
            end else begin
                do_ticks(vecs[i].n);
            end
            check_outputs($sformatf("vec%0d", i));
        end

        // Two more yellow ticks, then asynchronous reset between clock edges.
        do_ticks(2);
        push_exp({Y, R, R}, 2'd2, 2'd0, 5'd2, 1'b0);
        check_outputs("mid yellow");
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        push_exp({R, R, R}, 2'd0, 2'd2, 5'd2, 1'b0);
        check_outputs("async reset");
        @(negedge clk) rst = 1'b0;
        req = 3'b000;
        repeat (5) @(negedge clk);
        push_exp({R, R, R}, 2'd0, 2'd2, 5'd2, 1'b0);
        check_outputs("post reset idle");

        // Back-to-back tick cycles each count as one tick.
        @(negedge clk) tick = 1'b1;
        @(negedge clk);
        @(negedge clk) tick = 1'b0;
        push_exp({R, R, R}, 2'd0, 2'd2, 5'd0, 1'b0);
        check_outputs("double tick");

        // A request that comes and goes between ticks is never seen.
        @(negedge clk) req = 3'b010;
        @(negedge clk) req = 3'b000;
        do_ticks(1);
        push_exp({R, R, R}, 2'd0, 2'd2, 5'd0, 1'b0);
        check_outputs("req glitch");
        @(negedge clk) req = 3'b010; cnt1 = 4'd2;
        do_ticks(1);
        push_exp({R, G, R}, 2'd1, 2'd1, 5'd12, 1'b1);
        check_outputs("grant head1");
        @(negedge clk);
        push_exp({R, G, R}, 2'd1, 2'd1, 5'd12, 1'b0);
        check_outputs("handover one cycle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
